// File: rtl/lsu_pkg.sv
// Shared types and size encodings for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Size 2'b11 behaves as a word everywhere.
    function automatic logic is_misaligned(logic [1:0] size, logic [1:0] offs);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return offs[0];
            default: return (offs != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the LSU (master) and the memory system (slave).
interface lsu_if #(parameter int N = 32);

    logic         dmem_req;
    logic         dmem_we;
    logic [3:0]   dmem_be;
    logic [N-1:0] dmem_addr;
    logic [N-1:0] dmem_wdata;
    logic         dmem_gnt;
    logic         dmem_rvalid;
    logic [N-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: byte enables, store replication, load extraction/extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [1:0]   size,
    input  logic [1:0]   offs,
    input  logic         uns,
    input  logic         en,
    input  logic [N-1:0] wdata,
    input  logic [N-1:0] rdata,
    output logic [3:0]   be,
    output logic [N-1:0] wdata_rep,
    output logic [N-1:0] rdata_ext
);

    logic [1:0]   eff;
    logic [N-1:0] shifted;

    function automatic logic [N-1:0] extend(logic [N-1:0] v, logic [1:0] sz, logic u);
        case (sz)
            SZ_B:    return {{(N-8){v[7] & ~u}}, v[7:0]};
            SZ_H:    return {{(N-16){v[15] & ~u}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    // Misaligned halves/words fall back to lane 0 rather than straddling words.
    assign eff     = is_misaligned(size, offs) ? 2'b00 : offs;
    assign shifted = rdata >> {eff, 3'b000};

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        case (size)
            SZ_B: begin
                be        = 4'b0001 << eff;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_H: begin
                be        = 4'b0011 << eff;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
        if (!en) be = 4'b0000;
    end

    assign rdata_ext = extend(shifted, size, uns);

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding request FSM bridging the memory stage to the dmem bus.
// Define LSU_MISALIGN_TRAP_EN to flag and refuse misaligned half/word accesses.
module lsu
    import lsu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req,
    input  logic         we,
    input  logic [1:0]   size,
    input  logic         uns,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] wdata,
    output logic         stall,
    output logic         done,
    output logic [N-1:0] MEMread,
    output logic         misalign,
    lsu_if.master        dmem
);

    state_t       state, state_nxt;
    logic         accept;
    logic         load_cpl;
    logic         dreq;
    logic         l_we;
    logic [1:0]   l_size;
    logic         l_uns;
    logic [N-1:0] l_addr;
    logic [N-1:0] l_wdata;
    logic [3:0]   be;
    logic [N-1:0] wrep;
    logic [N-1:0] rext;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = rst_n && (state == IDLE) && req && is_misaligned(size, addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req && !misalign) begin
                    state_nxt = REQ;
                    accept    = 1'b1;
                end
            end
            REQ: begin
                if (dmem.dmem_gnt) state_nxt = dmem.dmem_rvalid ? DONE : WAIT;
            end
            WAIT: begin
                if (dmem.dmem_rvalid) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Request capture: the core may change its inputs once the access is latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_we    <= 1'b0;
            l_size  <= SZ_B;
            l_uns   <= 1'b0;
            l_addr  <= '0;
            l_wdata <= '0;
        end else if (accept) begin
            l_we    <= we;
            l_size  <= size;
            l_uns   <= uns;
            l_addr  <= addr;
            l_wdata <= wdata;
        end
    end

    assign load_cpl = !l_we && dmem.dmem_rvalid &&
                      (((state == REQ) && dmem.dmem_gnt) || (state == WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        MEMread <= '0;
        else if (load_cpl) MEMread <= rext;
    end

    lsu_align #(.N(N)) u_align (
        .size      (l_size),
        .offs      (l_addr[1:0]),
        .uns       (l_uns),
        .en        (dreq),
        .wdata     (l_wdata),
        .rdata     (dmem.dmem_rdata),
        .be        (be),
        .wdata_rep (wrep),
        .rdata_ext (rext)
    );

    assign dreq             = (state == REQ);
    assign dmem.dmem_req    = dreq;
    assign dmem.dmem_we     = dreq && l_we;
    assign dmem.dmem_be     = be;
    assign dmem.dmem_addr   = {l_addr[N-1:2], 2'b00};
    assign dmem.dmem_wdata  = wrep;

    assign done  = (state == DONE);
    assign stall = rst_n && ((state == REQ) || (state == WAIT) ||
                             ((state == IDLE) && req && !misalign));

endmodule
